// File: rtl/debounce_pkg.sv
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared state encodings and helpers for the switch debouncer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  // Debounced level is high while stable-high or qualifying a release
  function automatic logic is_high(input state_e s);
    return (s == ONE) || (s == WAIT0);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_ctrl_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Brief    : Free-running 2^Width tick counter with synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int Width = 19
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  // Terminal count M-1 is all ones; wrap to zero is the natural overflow
  assign tick_o = &r_cnt;

endmodule

`default_nettype wire

// File: rtl/debounce_ctrl.sv
// ============================================================================
// Module   : debounce_ctrl
// Brief    : Switch debouncer: synchronizer, qualification FSM, edge pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int Width    = 19,
  parameter int NumTicks = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                c_cnt_w = cnt_width(NumTicks);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NumTicks - 1);

  logic               r_sw_meta;
  logic               r_sw_s;
  state_e             r_state;
  state_e             w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic               w_clr;
  logic               w_tick;
  logic               r_rise;
  logic               r_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sw_meta <= 1'b0;
      r_sw_s    <= 1'b0;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_s    <= r_sw_meta;
    end
  end

  tick_gen #(
    .Width (Width)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_clr),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rise  <= is_high(w_state_next) & ~is_high(r_state);
      r_fall  <= ~is_high(w_state_next) & is_high(r_state);
    end
  end

  // A reversal is checked before the tick so it wins on the Nth tick
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clr        = 1'b0;
    case (r_state)
      ZERO: begin
        if (r_sw_s) begin
          w_state_next = WAIT1;
          w_cnt_next   = '0;
          w_clr        = 1'b1;
        end
      end
      WAIT1: begin
        if (!r_sw_s) begin
          w_state_next = ZERO;
        end else if (w_tick) begin
          if (r_cnt == c_last) w_state_next = ONE;
          else                 w_cnt_next   = r_cnt + c_cnt_w'(1);
        end
      end
      ONE: begin
        if (!r_sw_s) begin
          w_state_next = WAIT0;
          w_cnt_next   = '0;
          w_clr        = 1'b1;
        end
      end
      WAIT0: begin
        if (r_sw_s) begin
          w_state_next = ONE;
        end else if (w_tick) begin
          if (r_cnt == c_last) w_state_next = ZERO;
          else                 w_cnt_next   = r_cnt + c_cnt_w'(1);
        end
      end
      default: w_state_next = ZERO;
    endcase
  end

  assign db_o   = is_high(r_state);
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

`default_nettype wire

// File: doc/debounce_ctrl.md
DEBOUNCE_CTRL -- requirements
Module: debounce_ctrl

Interface
REQ-001 SHALL have parameter Width, default 19, meaning tick-period counter width; tick period M = 2^Width clocks (~5.2 ms at 100 MHz).
REQ-002 SHALL have parameter NumTicks, default 3, meaning consecutive stable ticks N required before the output changes; legal range N >= 1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sw_i, input, 1 bit: raw, asynchronous, bouncing switch level.
REQ-006 SHALL have port db_o, output, 1 bit: debounced level.
REQ-007 SHALL have port rise_o, output, 1 bit: one-cycle pulse on a db_o 0->1 transition.
REQ-008 SHALL have port fall_o, output, 1 bit: one-cycle pulse on a db_o 1->0 transition.

Function
REQ-009 SHALL pass sw_i through a two-flop synchronizer; sw_s is the second flop output, and only sw_s drives the FSM.
REQ-010 SHALL implement a four-state FSM: ZERO, WAIT1, ONE, WAIT0.
REQ-011 ZERO: sw_s=1 -> WAIT1, clear tick counter and stable-tick count; otherwise stay.
REQ-012 WAIT1: sw_s=0 -> ZERO (bounce rejected).
REQ-013 WAIT1: otherwise, on tick, stable-tick count = N-1 -> ONE; else increment the stable-tick count.
REQ-014 ONE: sw_s=0 -> WAIT0, clear tick counter and stable-tick count.
REQ-015 WAIT0 SHALL mirror WAIT1 with inverted polarity: sw_s=1 -> ONE; on the Nth tick -> ZERO.
REQ-016 Tick SHALL be asserted combinationally for one cycle when the tick counter equals M-1; the counter SHALL wrap M-1 -> 0 and otherwise free-run +1 per clock.
REQ-017 Clearing SHALL force the tick counter to 0 on the entry edge; clear SHALL take precedence over increment in the same cycle.
REQ-018 Stable-tick count width SHALL be clog2(N), minimum 1 bit; the count SHALL never exceed N-1.
REQ-019 db_o SHALL be 1 exactly when state is ONE or WAIT0, decoded from the registered state with no combinational path from sw_i.
REQ-020 Latency: if sw_s first reads 1 after edge s+1 and stays 1, db_o SHALL go 1 after edge s+2+N*M.
REQ-021 Falling latency SHALL be symmetric to REQ-020.
REQ-022 rise_o SHALL be registered and high for exactly the first cycle in which db_o=1; fall_o likewise for the first cycle in which db_o=0.
REQ-023 rise_o and fall_o SHALL never be high simultaneously.
REQ-024 A sw_s reversal in the same cycle as the Nth tick SHALL take priority: return to the stable state, with no output change and no pulse.

Reset
REQ-025 Asserting rst_i SHALL asynchronously force: state ZERO, synchronizer flops 0, tick counter 0, stable-tick count 0, db_o 0, rise_o 0, fall_o 0.
REQ-026 Reset asserted mid-WAIT1 or mid-WAIT0 SHALL abandon the qualification; no pulse SHALL be emitted during or on release of reset.
REQ-027 After reset release with sw_i held 1, the block SHALL qualify per REQ-020 and then pulse rise_o once.

Structure
REQ-028 State encodings ZERO, WAIT1, ONE and WAIT0 SHALL be defined as constants in shared package debounce_pkg, for bench reuse.
REQ-029 The tick counter SHALL be a sub-module tick_gen, parameterized by Width, with ports clk_i, rst_i, clr_i and tick_o; the FSM, synchronizer and pulse logic SHALL reside in debounce_ctrl.

Verification (Width=2, M=4, NumTicks=3, N*M=12)
REQ-030 Reset then sw_i=1 held -> db_o=1 exactly 14 edges after the first sampling edge; rise_o high 1 cycle; fall_o 0 throughout.
REQ-031 From db_o=1, sw_i=0 held -> db_o=0 after 14 edges; fall_o pulses once.
REQ-032 Bounce 1,0,1,0 every 3 cycles, then sw_i=1 held -> db_o rises 14 edges after the final 0->1; exactly one rise_o.
REQ-033 From ZERO, 11-cycle sw_i=1 glitch -> db_o stays 0; rise_o never asserts; FSM back in ZERO.
REQ-034 rst_i asserted 6 cycles into WAIT1 -> all outputs 0 immediately; after release with sw_i=1 -> full 14-edge qualification restarts.
REQ-035 sw_s drops in the cycle the 3rd tick is high -> state returns to ZERO; db_o stays 0; no pulse.
